// File: rtl/univ_shift_reg_if.sv
// Purpose : bundles the control, data and status signals of univ_shift_reg.
//           The master side (controller/testbench) drives the control and
//           serial/parallel inputs; the slave side (the shift register)
//           returns q, the serial outs, the shift count and the word pulse.
// Signals :
//   sclr      synchronous clear
//   en        clock enable
//   mode      00 hold, 01 shift right, 10 shift left, 11 parallel load
//   sin_r     serial in at the MSB for shift right
//   sin_l     serial in at the LSB for shift left
//   pdin      parallel load data
//   q         register contents
//   sout_r    q[0]
//   sout_l    q[WIDTH-1]
//   shift_cnt shifts since the last reset/clear/load, saturating at WIDTH
//   word_done one-cycle pulse after the WIDTH-th shift
interface univ_shift_reg_if #(
  parameter int WIDTH = 8
);
  localparam int CW = $clog2(WIDTH + 1);

  logic             sclr;
  logic             en;
  logic [1:0]       mode;
  logic             sin_r;
  logic             sin_l;
  logic [WIDTH-1:0] pdin;
  logic [WIDTH-1:0] q;
  logic             sout_r;
  logic             sout_l;
  logic [CW-1:0]    shift_cnt;
  logic             word_done;

  modport master (
    output sclr, en, mode, sin_r, sin_l, pdin,
    input  q, sout_r, sout_l, shift_cnt, word_done
  );

  modport slave (
    input  sclr, en, mode, sin_r, sin_l, pdin,
    output q, sout_r, sout_l, shift_cnt, word_done
  );
endinterface

// File: rtl/univ_shift_reg.sv
// Purpose : parametrised universal shift register with hold, shift right,
//           shift left and parallel load, serial in/out at both ends, a
//           saturating shift counter and a registered word-complete pulse.
// Ports   :
//   clk    rising-edge clock
//   reset  asynchronous, active-high reset
//   bus    univ_shift_reg_if slave modport (controls in, q/status out)
// Parameters:
//   WIDTH    register width, >= 2
//   RST_VAL  value loaded on reset and on sclr
module univ_shift_reg #(
  parameter int               WIDTH   = 8,
  parameter logic [WIDTH-1:0] RST_VAL = '0
) (
  input  logic                   clk,
  input  logic                   reset,
  univ_shift_reg_if.slave        bus
);
  localparam int            CW      = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(WIDTH);
  localparam logic [CW-1:0] CNT_PRE = CW'(WIDTH - 1);

  logic [WIDTH-1:0] data_q, data_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             done_q, done_d;
  logic             shift_en;

  always_comb begin
    data_d   = data_q;
    cnt_d    = cnt_q;
    done_d   = 1'b0;   // pulse always self-clears on the next edge
    shift_en = 1'b0;
    if (bus.sclr) begin
      data_d = RST_VAL;
      cnt_d  = '0;
    end else if (bus.en) begin
      case (bus.mode)
        2'b01: begin
          data_d   = {bus.sin_r, data_q[WIDTH-1:1]};
          shift_en = 1'b1;
        end
        2'b10: begin
          data_d   = {data_q[WIDTH-2:0], bus.sin_l};
          shift_en = 1'b1;
        end
        2'b11: begin
          data_d = bus.pdin;
          cnt_d  = '0;
        end
        default: ;
      endcase
      // Only the transition into saturation fires the pulse, so a saturated
      // counter keeps shifting data silently until a load/clear re-arms it.
      if (shift_en && (cnt_q != CNT_MAX)) begin
        cnt_d  = cnt_q + CW'(1);
        done_d = (cnt_q == CNT_PRE);
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      data_q <= RST_VAL;
      cnt_q  <= '0;
      done_q <= 1'b0;
    end else begin
      data_q <= data_d;
      cnt_q  <= cnt_d;
      done_q <= done_d;
    end
  end

  assign bus.q         = data_q;
  assign bus.sout_r    = data_q[0];
  assign bus.sout_l    = data_q[WIDTH-1];
  assign bus.shift_cnt = cnt_q;
  assign bus.word_done = done_q;
endmodule

// File: tb/tb_univ_shift_reg.sv
module tb_univ_shift_reg;
  localparam int W = 4;

  logic clk;
  logic reset;
  int   n_cmp = 0;
  int   n_err = 0;

  univ_shift_reg_if #(.WIDTH(W)) bus0 ();
  univ_shift_reg_if #(.WIDTH(W)) bus1 ();

  univ_shift_reg #(.WIDTH(W), .RST_VAL(4'h0)) dut0 (.clk(clk), .reset(reset), .bus(bus0));
  univ_shift_reg #(.WIDTH(W), .RST_VAL(4'hA)) dut1 (.clk(clk), .reset(reset), .bus(bus1));

  assign bus1.sclr  = bus0.sclr;
  assign bus1.en    = bus0.en;
  assign bus1.mode  = bus0.mode;
  assign bus1.sin_r = bus0.sin_r;
  assign bus1.sin_l = bus0.sin_l;
  assign bus1.pdin  = bus0.pdin;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_state(input string tag, input logic [3:0] eq, input int ecnt, input logic edone);
    chk({tag, ".q"}, 32'(bus0.q), 32'(eq));
    chk({tag, ".cnt"}, 32'(bus0.shift_cnt), 32'(ecnt));
    chk({tag, ".done"}, 32'(bus0.word_done), 32'(edone));
  endtask

  logic [3:0] mq;
  int         mcnt;
  logic       mdone;
  logic [3:0] sr_bits;
  logic [3:0] sl_exp;

  initial begin
    reset = 1'b1;
    bus0.sclr = 1'b0; bus0.en = 1'b0; bus0.mode = 2'b00;
    bus0.sin_r = 1'b0; bus0.sin_l = 1'b0; bus0.pdin = 4'h0;
    #1;
    chk_state("por", 4'h0, 0, 1'b0);
    chk("por.q1", 32'(bus1.q), 32'hA);
    @(negedge clk);
    reset = 1'b0;

    // 1: reset mid-stream acts without a clock edge
    bus0.en = 1'b1; bus0.mode = 2'b11; bus0.pdin = 4'b1011;
    step();
    chk_state("t1.load", 4'b1011, 0, 1'b0);
    bus0.mode = 2'b01; bus0.sin_r = 1'b0;
    step();
    chk_state("t1.shift", 4'b0101, 1, 1'b0);
    reset = 1'b1;
    #1;
    chk_state("t1.async_rst", 4'h0, 0, 1'b0);
    chk("t1.async_rst.q1", 32'(bus1.q), 32'hA);
    #1;
    reset = 1'b0;
    bus0.mode = 2'b00;
    for (int i = 0; i < 3; i++) begin
      step();
      chk_state("t1.hold", 4'h0, 0, 1'b0);
    end

    // 2: shift right 1,0,1,1 then a fifth shift
    sr_bits = 4'b1101;   // applied LSB first: 1,0,1,1
    bus0.mode = 2'b01;
    bus0.sin_r = sr_bits[0]; step();
    chk_state("t2.s1", 4'b1000, 1, 1'b0); chk("t2.s1.sout_r", 32'(bus0.sout_r), 32'd0);
    bus0.sin_r = sr_bits[1]; step();
    chk_state("t2.s2", 4'b0100, 2, 1'b0); chk("t2.s2.sout_r", 32'(bus0.sout_r), 32'd0);
    bus0.sin_r = sr_bits[2]; step();
    chk_state("t2.s3", 4'b1010, 3, 1'b0); chk("t2.s3.sout_r", 32'(bus0.sout_r), 32'd0);
    bus0.sin_r = sr_bits[3]; step();
    chk_state("t2.s4", 4'b1101, 4, 1'b1); chk("t2.s4.sout_r", 32'(bus0.sout_r), 32'd1);
    bus0.sin_r = 1'b0; step();
    chk_state("t2.s5_sat", 4'b0110, 4, 1'b0);

    // 3: load 1001, shift left with zeros, load right after word_done
    bus0.mode = 2'b11; bus0.pdin = 4'b1001;
    step();
    chk_state("t3.load", 4'b1001, 0, 1'b0);
    sl_exp = 4'b1001;    // sout_l before each edge, MSB first
    bus0.mode = 2'b10; bus0.sin_l = 1'b0;
    for (int i = 0; i < 4; i++) begin
      chk("t3.sout_l", 32'(bus0.sout_l), 32'(sl_exp[3-i]));
      step();
    end
    chk_state("t3.end", 4'b0000, 4, 1'b1);
    bus0.mode = 2'b11; bus0.pdin = 4'b0110;
    step();
    chk_state("t3.load_after_done", 4'b0110, 0, 1'b0);

    // 4: enable gating, one shift per enabled clock, done clears with en=0
    bus0.en = 1'b0; bus0.mode = 2'b01; bus0.sin_r = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      chk_state("t4.en0", 4'b0110, 0, 1'b0);
    end
    bus0.en = 1'b1;
    step();
    chk_state("t4.en1", 4'b1011, 1, 1'b0);
    bus0.en = 1'b0;
    step();
    chk_state("t4.en0b", 4'b1011, 1, 1'b0);
    bus0.en = 1'b1; bus0.sin_r = 1'b0;
    step(); chk_state("t4.a", 4'b0101, 2, 1'b0);
    step(); chk_state("t4.b", 4'b0010, 3, 1'b0);
    step(); chk_state("t4.c", 4'b0001, 4, 1'b1);
    bus0.en = 1'b0;
    step(); chk_state("t4.done_clr_en0", 4'b0001, 4, 1'b0);

    // 5: direction change keeps count; sclr beats load
    bus0.en = 1'b1; bus0.mode = 2'b11; bus0.pdin = 4'b0110;
    step();
    bus0.mode = 2'b10; bus0.sin_l = 1'b0;
    step(); chk_state("t5.left", 4'b1100, 1, 1'b0);
    bus0.mode = 2'b01; bus0.sin_r = 1'b0;
    step(); chk_state("t5.right", 4'b0110, 2, 1'b0);
    bus0.sclr = 1'b1; bus0.mode = 2'b11; bus0.pdin = 4'b1111;
    step();
    chk_state("t5.sclr", 4'b0000, 0, 1'b0);
    chk("t5.sclr.q1", 32'(bus1.q), 32'hA);
    chk("t5.sclr.cnt1", 32'(bus1.shift_cnt), 32'd0);
    bus0.sclr = 1'b0;

    // 6: random traffic against a behavioural model
    mq = 4'h0; mcnt = 0; mdone = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      bus0.sclr  = ($urandom_range(15) == 0);
      bus0.en    = ($urandom_range(7) != 0);
      bus0.mode  = 2'($urandom_range(3));
      bus0.sin_r = 1'($urandom);
      bus0.sin_l = 1'($urandom);
      bus0.pdin  = 4'($urandom);
      mdone = 1'b0;
      if (bus0.sclr) begin
        mq = 4'h0; mcnt = 0;
      end else if (bus0.en) begin
        if (bus0.mode == 2'b01 || bus0.mode == 2'b10) begin
          if (bus0.mode == 2'b01) mq = (mq >> 1) | (4'(bus0.sin_r) << 3);
          else                    mq = (mq << 1) | 4'(bus0.sin_l);
          if (mcnt < W) begin
            mcnt++;
            mdone = (mcnt == W);
          end
        end else if (bus0.mode == 2'b11) begin
          mq = bus0.pdin; mcnt = 0;
        end
      end
      step();
      chk_state("t6.rand", mq, mcnt, mdone);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
